adxl362_spi_responder: RTL and testbench

Synthesizable SPI-mode-0 slave that models the on-board ADXL362 accelerometer. It is the responder end of the accelerometer link driven by the team's SPI master.
- Used in simulation and on-board loopback so the accelerometer path can be tested without the physical sensor.
- Oversamples SCLK/CSN/MOSI on a fast system clock.
- Decodes read/write commands, serves a 64-byte register map, and injects X/Y/Z samples from ports.

---
 rtl/adxl362_pkg.sv | 48 ++++
 rtl/adxl362_spi_responder_sync.sv | 49 ++++
 rtl/adxl362_spi_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_adxl362_spi_responder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adxl362_pkg.sv
// Shared constants, register addresses and FSM state type for the ADXL362 SPI responder.
`timescale 1ns/1ps
package adxl362_pkg;

   localparam logic [7:0] CMD_READ       = 8'h0B;
   localparam logic [7:0] CMD_WRITE      = 8'h0A;
   localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
   localparam logic [7:0] DEVID_AD_VAL   = 8'hAD;
   localparam logic [7:0] DEVID_MST_VAL  = 8'h1D;

   localparam logic [5:0] ADDR_DEVID_AD   = 6'h00;
   localparam logic [5:0] ADDR_DEVID_MST  = 6'h01;
   localparam logic [5:0] ADDR_PARTID     = 6'h02;
   localparam logic [5:0] ADDR_REVID      = 6'h03;
   localparam logic [5:0] ADDR_XDATA      = 6'h08;
   localparam logic [5:0] ADDR_YDATA      = 6'h09;
   localparam logic [5:0] ADDR_ZDATA      = 6'h0A;
   localparam logic [5:0] ADDR_STATUS     = 6'h0B;
   localparam logic [5:0] ADDR_XDATA_L    = 6'h0E;
   localparam logic [5:0] ADDR_XDATA_H    = 6'h0F;
   localparam logic [5:0] ADDR_YDATA_L    = 6'h10;
   localparam logic [5:0] ADDR_YDATA_H    = 6'h11;
   localparam logic [5:0] ADDR_ZDATA_L    = 6'h12;
   localparam logic [5:0] ADDR_ZDATA_H    = 6'h13;
   localparam logic [5:0] ADDR_SOFT_RESET = 6'h1F;
   localparam logic [5:0] ADDR_WR_FIRST   = 6'h20;
   localparam logic [5:0] ADDR_WR_LAST    = 6'h2E;
   localparam logic [5:0] ADDR_FILTER_CTL = 6'h2C;
   localparam logic [5:0] ADDR_POWER_CTL  = 6'h2D;

   // Writable bank 0x20..0x2E is indexed by the low address nibble.
   localparam int NUM_WREGS  = 15;
   localparam int FILTER_IDX = int'(ADDR_FILTER_CTL) - int'(ADDR_WR_FIRST);
   localparam int POWER_IDX  = int'(ADDR_POWER_CTL) - int'(ADDR_WR_FIRST);

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StData,
      StIgnore
   } spi_state_e;

   function automatic logic is_writable(input logic [5:0] addr);
      return (addr >= ADDR_WR_FIRST) && (addr <= ADDR_WR_LAST);
   endfunction

endpackage

// File: rtl/adxl362_spi_responder_sync.sv
// Multi-flop synchronizer for the SPI pins with edge detection on CSN and SCLK.
`timescale 1ns/1ps
module spi_slave_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_arst_n,
   input  logic i_spi_csn,
   input  logic i_spi_sclk,
   input  logic i_spi_mosi,
   output logic o_csn_sync,
   output logic o_csn_fall,
   output logic o_csn_rise,
   output logic o_sclk_rise,
   output logic o_sclk_fall,
   output logic o_mosi_sync
);

   logic [SYNC_STAGES-1:0] r_csn_ff;
   logic [SYNC_STAGES-1:0] r_sclk_ff;
   logic [SYNC_STAGES-1:0] r_mosi_ff;
   logic                   r_csn_prev;
   logic                   r_sclk_prev;

   // CSN resets to the deselected level so no spurious fall follows reset.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_csn_ff    <= '1;
         r_sclk_ff   <= '0;
         r_mosi_ff   <= '0;
         r_csn_prev  <= 1'b1;
         r_sclk_prev <= 1'b0;
      end else begin
         r_csn_ff    <= {r_csn_ff[SYNC_STAGES-2:0], i_spi_csn};
         r_sclk_ff   <= {r_sclk_ff[SYNC_STAGES-2:0], i_spi_sclk};
         r_mosi_ff   <= {r_mosi_ff[SYNC_STAGES-2:0], i_spi_mosi};
         r_csn_prev  <= r_csn_ff[SYNC_STAGES-1];
         r_sclk_prev <= r_sclk_ff[SYNC_STAGES-1];
      end
   end

   assign o_csn_sync  = r_csn_ff[SYNC_STAGES-1];
   assign o_mosi_sync = r_mosi_ff[SYNC_STAGES-1];
   assign o_csn_fall  = r_csn_prev & ~r_csn_ff[SYNC_STAGES-1];
   assign o_csn_rise  = ~r_csn_prev & r_csn_ff[SYNC_STAGES-1];
   assign o_sclk_rise = ~r_sclk_prev & r_sclk_ff[SYNC_STAGES-1];
   assign o_sclk_fall = r_sclk_prev & ~r_sclk_ff[SYNC_STAGES-1];

endmodule

// File: rtl/adxl362_spi_responder.sv
// SPI mode-0 slave emulating the ADXL362: command decode, 64-byte register map, sample injection.
`timescale 1ns/1ps
module adxl362_spi_responder
   import adxl362_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter logic [7:0]  PARTID         = 8'hF2,
   parameter logic [7:0]  REVID          = 8'h01,
   parameter logic [7:0]  FILTER_DEFAULT = 8'h13
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        spi_csn,
   input  logic        spi_sclk,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   input  logic [11:0] accel_x_i,
   input  logic [11:0] accel_y_i,
   input  logic [11:0] accel_z_i,
   input  logic        sample_valid_i,
   output logic [7:0]  power_ctl_o,
   output logic        measure_mode_o,
   output logic        wr_strobe_o,
   output logic [5:0]  wr_addr_o,
   output logic [7:0]  wr_data_o,
   output logic        cmd_error_o
);

   function automatic logic [7:0] wreg_default(input int idx);
      return (idx == FILTER_IDX) ? FILTER_DEFAULT : 8'h00;
   endfunction

   logic w_csn_sync, w_csn_fall, w_csn_rise, w_sclk_rise, w_sclk_fall, w_mosi_sync;

   spi_slave_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .i_clk       (clk),
      .i_arst_n    (arst_n),
      .i_spi_csn   (spi_csn),
      .i_spi_sclk  (spi_sclk),
      .i_spi_mosi  (spi_mosi),
      .o_csn_sync  (w_csn_sync),
      .o_csn_fall  (w_csn_fall),
      .o_csn_rise  (w_csn_rise),
      .o_sclk_rise (w_sclk_rise),
      .o_sclk_fall (w_sclk_fall),
      .o_mosi_sync (w_mosi_sync)
   );

   spi_state_e  r_state, w_state_d;
   logic [2:0]  r_bit_cnt;
   logic [6:0]  r_shift_in;
   logic [7:0]  r_shift_out;
   logic [5:0]  r_addr;
   logic        r_is_read;
   logic        r_load_pending;
   logic [11:0] r_x, r_y, r_z, r_sx, r_sy, r_sz;
   logic        r_ready, r_sready;
   logic [7:0]  r_wregs [NUM_WREGS];
   logic        r_wr_strobe, r_cmd_error;
   logic [5:0]  r_wr_addr;
   logic [7:0]  r_wr_data;

   logic       w_byte_done;
   logic [7:0] w_byte;
   logic [7:0] w_rd_data;
   logic       w_snapshot, w_cmd_err, w_set_read, w_set_write, w_addr_done, w_data_done;

   assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
   assign w_byte      = {r_shift_in, w_mosi_sync};

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) r_state <= StIdle;
      else         r_state <= w_state_d;
   end

   always_comb begin
      w_state_d   = r_state;
      w_snapshot  = 1'b0;
      w_cmd_err   = 1'b0;
      w_set_read  = 1'b0;
      w_set_write = 1'b0;
      w_addr_done = 1'b0;
      w_data_done = 1'b0;
      if (w_csn_rise) begin
         w_state_d = StIdle;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_csn_fall) begin
                  w_snapshot = 1'b1;
                  w_state_d  = StCmd;
               end
            end
            StCmd: begin
               if (w_byte_done) begin
                  if (w_byte == CMD_READ) begin
                     w_set_read = 1'b1;
                     w_state_d  = StAddr;
                  end else if (w_byte == CMD_WRITE) begin
                     w_set_write = 1'b1;
                     w_state_d   = StAddr;
                  end else begin
                     w_cmd_err = 1'b1;
                     w_state_d = StIgnore;
                  end
               end
            end
            StAddr: begin
               if (w_byte_done) begin
                  w_addr_done = 1'b1;
                  w_state_d   = StData;
               end
            end
            StData:   w_data_done = w_byte_done;
            StIgnore: w_state_d = StIgnore;
            default:  w_state_d = StIdle;
         endcase
      end
   end

   // Reads always come from the shadow copy taken at CSN fall.
   always_comb begin
      w_rd_data = 8'h00;
      case (r_addr)
         ADDR_DEVID_AD:  w_rd_data = DEVID_AD_VAL;
         ADDR_DEVID_MST: w_rd_data = DEVID_MST_VAL;
         ADDR_PARTID:    w_rd_data = PARTID;
         ADDR_REVID:     w_rd_data = REVID;
         ADDR_XDATA:     w_rd_data = r_sx[11:4];
         ADDR_YDATA:     w_rd_data = r_sy[11:4];
         ADDR_ZDATA:     w_rd_data = r_sz[11:4];
         ADDR_STATUS:    w_rd_data = {7'b0, r_sready};
         ADDR_XDATA_L:   w_rd_data = r_sx[7:0];
         ADDR_XDATA_H:   w_rd_data = {{4{r_sx[11]}}, r_sx[11:8]};
         ADDR_YDATA_L:   w_rd_data = r_sy[7:0];
         ADDR_YDATA_H:   w_rd_data = {{4{r_sy[11]}}, r_sy[11:8]};
         ADDR_ZDATA_L:   w_rd_data = r_sz[7:0];
         ADDR_ZDATA_H:   w_rd_data = {{4{r_sz[11]}}, r_sz[11:8]};
         default: begin
            if (is_writable(r_addr)) w_rd_data = r_wregs[r_addr[3:0]];
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_bit_cnt      <= '0;
         r_shift_in     <= '0;
         r_shift_out    <= '0;
         r_addr         <= '0;
         r_is_read      <= 1'b0;
         r_load_pending <= 1'b0;
         r_x            <= '0;
         r_y            <= '0;
         r_z            <= '0;
         r_ready        <= 1'b0;
         r_sx           <= '0;
         r_sy           <= '0;
         r_sz           <= '0;
         r_sready       <= 1'b0;
         for (int i = 0; i < NUM_WREGS; i++) r_wregs[i] <= wreg_default(i);
         r_wr_strobe    <= 1'b0;
         r_wr_addr      <= '0;
         r_wr_data      <= '0;
         r_cmd_error    <= 1'b0;
      end else begin
         r_wr_strobe <= 1'b0;
         r_cmd_error <= w_cmd_err;
         if (sample_valid_i) begin
            r_x     <= accel_x_i;
            r_y     <= accel_y_i;
            r_z     <= accel_z_i;
            r_ready <= 1'b1;
         end
         // A sample arriving with CSN fall is the one captured.
         if (w_snapshot) begin
            r_sx           <= sample_valid_i ? accel_x_i : r_x;
            r_sy           <= sample_valid_i ? accel_y_i : r_y;
            r_sz           <= sample_valid_i ? accel_z_i : r_z;
            r_sready       <= sample_valid_i | r_ready;
            r_ready        <= 1'b0;
            r_bit_cnt      <= '0;
            r_load_pending <= 1'b0;
         end
         if (w_sclk_rise && (r_state != StIdle)) begin
            r_shift_in <= w_byte[6:0];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
         end
         if (w_set_read)  r_is_read <= 1'b1;
         if (w_set_write) r_is_read <= 1'b0;
         if (w_addr_done) begin
            r_addr         <= w_byte[5:0];
            r_load_pending <= r_is_read;
         end
         if (w_data_done) begin
            r_addr <= r_addr + 6'd1;
            if (r_is_read) begin
               r_load_pending <= 1'b1;
            end else if (is_writable(r_addr)) begin
               r_wregs[r_addr[3:0]] <= w_byte;
               r_wr_strobe          <= 1'b1;
               r_wr_addr            <= r_addr;
               r_wr_data            <= w_byte;
            end else if ((r_addr == ADDR_SOFT_RESET) && (w_byte == SOFT_RESET_KEY)) begin
               for (int i = 0; i < NUM_WREGS; i++) r_wregs[i] <= wreg_default(i);
               r_wr_strobe <= 1'b1;
               r_wr_addr   <= r_addr;
               r_wr_data   <= w_byte;
            end
         end
         // The first fall after a completed byte loads the next register; later falls shift.
         if (w_sclk_fall && (r_state == StData) && r_is_read) begin
            if (r_load_pending) begin
               r_shift_out    <= w_rd_data;
               r_load_pending <= 1'b0;
            end else begin
               r_shift_out <= {r_shift_out[6:0], 1'b0};
            end
         end
      end
   end

   assign spi_miso_oe    = ~w_csn_sync;
   assign spi_miso       = ((r_state == StData) && r_is_read) ? r_shift_out[7] : 1'b0;
   assign power_ctl_o    = r_wregs[POWER_IDX];
   assign measure_mode_o = (r_wregs[POWER_IDX][1:0] == 2'b10);
   assign wr_strobe_o    = r_wr_strobe;
   assign wr_addr_o      = r_wr_addr;
   assign wr_data_o      = r_wr_data;
   assign cmd_error_o    = r_cmd_error;

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Randomized scoreboard bench: an SPI master drives transactions, monitors compare MISO and strobes.
`timescale 1ns/1ps
module tb_adxl362_spi_responder;

   localparam int HALF = 60;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        spi_csn = 1'b1;
   logic        spi_sclk = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_miso, spi_miso_oe;
   logic [11:0] accel_x_i = '0, accel_y_i = '0, accel_z_i = '0;
   logic        sample_valid_i = 1'b0;
   logic [7:0]  power_ctl_o;
   logic        measure_mode_o;
   logic        wr_strobe_o;
   logic [5:0]  wr_addr_o;
   logic [7:0]  wr_data_o;
   logic        cmd_error_o;

   adxl362_spi_responder dut (
      .clk            (clk),
      .arst_n         (arst_n),
      .spi_csn        (spi_csn),
      .spi_sclk       (spi_sclk),
      .spi_mosi       (spi_mosi),
      .spi_miso       (spi_miso),
      .spi_miso_oe    (spi_miso_oe),
      .accel_x_i      (accel_x_i),
      .accel_y_i      (accel_y_i),
      .accel_z_i      (accel_z_i),
      .sample_valid_i (sample_valid_i),
      .power_ctl_o    (power_ctl_o),
      .measure_mode_o (measure_mode_o),
      .wr_strobe_o    (wr_strobe_o),
      .wr_addr_o      (wr_addr_o),
      .wr_data_o      (wr_data_o),
      .cmd_error_o    (cmd_error_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [11:0] m_x = '0, m_y = '0, m_z = '0, m_sx = '0, m_sy = '0, m_sz = '0;
   bit          m_ready = 1'b0, m_sready = 1'b0;
   logic [7:0]  m_wregs [64];
   int          exp_err_pulses = 0;
   int          err_cycles = 0;

   logic [7:0]  miso_q [$];
   logic [13:0] wr_q [$];
   logic [7:0]  tq [$];
   logic [13:0] wr_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic void soft_defaults();
      for (int a = 0; a < 64; a++) m_wregs[a] = 8'h00;
      m_wregs[6'h2C] = 8'h13;
   endfunction

   function automatic logic [7:0] m_read(input logic [5:0] a);
      case (a)
         6'h00: return 8'hAD;
         6'h01: return 8'h1D;
         6'h02: return 8'hF2;
         6'h03: return 8'h01;
         6'h08: return m_sx[11:4];
         6'h09: return m_sy[11:4];
         6'h0A: return m_sz[11:4];
         6'h0B: return {7'b0, m_sready};
         6'h0E: return m_sx[7:0];
         6'h0F: return {{4{m_sx[11]}}, m_sx[11:8]};
         6'h10: return m_sy[7:0];
         6'h11: return {{4{m_sy[11]}}, m_sy[11:8]};
         6'h12: return m_sz[7:0];
         6'h13: return {{4{m_sz[11]}}, m_sz[11:8]};
         default: return (a >= 6'h20 && a <= 6'h2E) ? m_wregs[a] : 8'h00;
      endcase
   endfunction

   function automatic void model_write(input logic [5:0] a, input logic [7:0] d);
      if (a >= 6'h20 && a <= 6'h2E) begin
         m_wregs[a] = d;
         wr_q.push_back({a, d});
      end else if (a == 6'h1F && d == 8'h52) begin
         soft_defaults();
         wr_q.push_back({a, d});
      end
   endfunction

   task automatic spi_bit(input logic v);
      spi_mosi = v;
      #HALF spi_sclk = 1'b1;
      #HALF spi_sclk = 1'b0;
   endtask

   // Predict every full MISO byte and write strobe, then drive the pins.
   task automatic run_txn(input logic [7:0] b[$], input int tail_bits);
      logic [7:0] cmd;
      logic [7:0] e;
      logic [7:0] cur;
      logic [5:0] a;
      m_sx = m_x; m_sy = m_y; m_sz = m_z;
      m_sready = m_ready;
      m_ready = 1'b0;
      cmd = b[0];
      a = 6'h00;
      if (cmd != 8'h0A && cmd != 8'h0B) exp_err_pulses++;
      for (int i = 0; i < b.size(); i++) begin
         e = 8'h00;
         if (i == 1) a = b[1][5:0];
         if (i >= 2) begin
            if (cmd == 8'h0B)      e = m_read(a);
            else if (cmd == 8'h0A) model_write(a, b[i]);
            a = a + 6'd1;
         end
         miso_q.push_back(e);
      end
      @(negedge clk);
      #2 spi_csn = 1'b0;
      #100;
      for (int i = 0; i < b.size(); i++) begin
         cur = b[i];
         for (int k = 7; k >= 0; k--) spi_bit(cur[k]);
      end
      for (int k = 0; k < tail_bits; k++) spi_bit(1'($urandom));
      #100 spi_csn = 1'b1;
      #30 check("miso_oe_release", {31'b0, spi_miso_oe}, 32'd0);
      #270;
   endtask

   task automatic do_sample(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
      @(negedge clk);
      accel_x_i = x; accel_y_i = y; accel_z_i = z;
      sample_valid_i = 1'b1;
      m_x = x; m_y = y; m_z = z; m_ready = 1'b1;
      @(negedge clk);
      sample_valid_i = 1'b0;
   endtask

   task automatic check_power();
      @(negedge clk);
      check("power_ctl", {24'b0, power_ctl_o}, {24'b0, m_wregs[6'h2D]});
      check("measure_mode", {31'b0, measure_mode_o}, {31'b0, m_wregs[6'h2D][1:0] == 2'b10});
   endtask

   // MISO monitor: assembles bytes at master sample points and pops the scoreboard.
   initial begin : miso_mon
      logic [7:0] sh;
      logic [7:0] exp_b;
      int nb;
      bit oe_ok;
      forever begin
         @(negedge spi_csn);
         nb = 0; sh = '0; oe_ok = 1'b1;
         while (spi_csn === 1'b0) begin
            @(posedge spi_sclk or posedge spi_csn);
            if (spi_csn === 1'b0) begin
               sh = {sh[6:0], spi_miso};
               if (spi_miso_oe !== 1'b1) oe_ok = 1'b0;
               nb++;
               if (nb == 8) begin
                  nb = 0;
                  if (miso_q.size() == 0) begin
                     checks++; failures++;
                     $display("FAIL miso_unexpected actual=0x%0h required=none", sh);
                  end else begin
                     exp_b = miso_q.pop_front();
                     check("miso_byte", {24'b0, sh}, {24'b0, exp_b});
                  end
                  check("miso_oe_held", {31'b0, oe_ok}, 32'd1);
                  oe_ok = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (wr_strobe_o === 1'b1) begin
         if (wr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL wr_strobe_unexpected actual=0x%0h required=none", {wr_addr_o, wr_data_o});
         end else begin
            wr_exp = wr_q.pop_front();
            check("wr_strobe", {18'b0, wr_addr_o, wr_data_o}, {18'b0, wr_exp});
         end
      end
      if (cmd_error_o === 1'b1) err_cycles++;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      soft_defaults();
      #45 arst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_miso", {31'b0, spi_miso}, 32'd0);
      check("rst_miso_oe", {31'b0, spi_miso_oe}, 32'd0);
      check("rst_power_ctl", {24'b0, power_ctl_o}, 32'd0);
      check("rst_measure", {31'b0, measure_mode_o}, 32'd0);
      check("rst_wr", {17'b0, wr_strobe_o, wr_addr_o, wr_data_o}, 32'd0);
      check("rst_cmd_error", {31'b0, cmd_error_o}, 32'd0);

      tq = '{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_txn(tq, 0);
      tq = '{8'h0A, 8'h2D, 8'h02};
      run_txn(tq, 0);
      check_power();
      tq = '{8'h0A, 8'h08, 8'h55};
      run_txn(tq, 0);
      tq = '{8'h0B, 8'h08, 8'h00};
      run_txn(tq, 0);

      do_sample(12'hFFB, 12'h123, 12'h800);
      tq = '{8'h0B, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_txn(tq, 0);
      tq = '{8'h0B, 8'h0B, 8'h00};
      run_txn(tq, 0);

      // Sample lands mid-burst: burst keeps the old snapshot.
      tq = '{8'h0B, 8'h08, 8'h00, 8'h00, 8'h00};
      fork
         run_txn(tq, 0);
         begin
            #2000;
            do_sample(12'h7F3, 12'h456, 12'h9AB);
         end
      join
      tq = '{8'h0B, 8'h08, 8'h00};
      run_txn(tq, 0);

      tq = '{8'h55, 8'hFF, 8'hA5};
      run_txn(tq, 0);
      tq = '{8'h0A, 8'h2A, 8'h5A};
      run_txn(tq, 0);
      tq = '{8'h0A, 8'h2A};
      run_txn(tq, 5);
      tq = '{8'h0B, 8'h2A, 8'h00};
      run_txn(tq, 0);

      tq = '{8'h0A, 8'h2C, 8'h00};
      run_txn(tq, 0);
      tq = '{8'h0B, 8'h2C, 8'h00};
      run_txn(tq, 0);
      tq = '{8'h0A, 8'h1F, 8'h52};
      run_txn(tq, 0);
      tq = '{8'h0B, 8'h2C, 8'h00, 8'h00};
      run_txn(tq, 0);
      check_power();
      tq = '{8'h0B, 8'h3F, 8'h00, 8'h00};
      run_txn(tq, 0);

      for (int it = 0; it < 40; it++) begin
         int sel;
         int n;
         logic [7:0] ab;
         logic [7:0] c;
         sel = $urandom_range(0, 9);
         tq.delete();
         ab = 8'($urandom);
         if (sel <= 3) begin
            if ($urandom_range(0, 1) == 1) ab[5:0] = 6'($urandom_range(0, 19));
            tq.push_back(8'h0B);
            tq.push_back(ab);
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) tq.push_back(8'($urandom));
            run_txn(tq, 0);
         end else if (sel <= 6) begin
            if ($urandom_range(0, 3) != 0) ab[5:0] = 6'($urandom_range(28, 47));
            tq.push_back(8'h0A);
            if ($urandom_range(0, 5) == 0) begin
               tq.push_back(8'h1F);
               tq.push_back(8'h52);
            end else begin
               tq.push_back(ab);
               n = $urandom_range(1, 3);
               for (int j = 0; j < n; j++) tq.push_back(8'($urandom));
            end
            run_txn(tq, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
            check_power();
         end else if (sel == 7) begin
            c = 8'($urandom);
            if (c == 8'h0A || c == 8'h0B) c = 8'h00;
            tq.push_back(c);
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) tq.push_back(8'($urandom));
            run_txn(tq, 0);
         end else begin
            do_sample(12'($urandom), 12'($urandom), 12'($urandom));
         end
      end

      #1000;
      check("miso_queue_drained", miso_q.size(), 32'd0);
      check("wr_queue_drained", wr_q.size(), 32'd0);
      check("cmd_error_pulses", err_cycles, exp_err_pulses);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
